// File: rtl/bk_pkg.sv
// rtl/bk_pkg.sv - shared types and helpers for the backup RAM sector sequencer
package bk_pkg;

   localparam int SECTOR_BYTES = 512;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2,
      ST_DONE = 2'd3
   } bk_state_e;

   function automatic logic [7:0] lba_last(input int sectors);
      return 8'(sectors - 1);
   endfunction

endpackage

// File: rtl/bk_sector_seq_if.sv
// rtl/bk_sector_seq_if.sv - user_io SD sector handshake bundle
interface bk_sector_seq_if;

   logic [31:0] sd_lba;
   logic        sd_rd;
   logic        sd_wr;
   logic        sd_ack;

   modport master (output sd_lba, output sd_rd, output sd_wr, input sd_ack);
   modport slave  (input sd_lba, input sd_rd, input sd_wr, output sd_ack);

endinterface

// File: rtl/bk_autosave_timer.sv
// rtl/bk_autosave_timer.sv - dirty flag plus idle counter; fires a save request after CYC quiet cycles
module bk_autosave_timer #(
   parameter int unsigned CYC = 32'd16777215
) (
   input  logic clk,
   input  logic rst_n,
   input  logic we,
   input  logic enable,
   input  logic clear,
   output logic fire
);

   localparam int CW = (CYC < 2) ? 1 : $clog2(CYC + 1);

   logic          dirty_q, dirty_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fire_q, fire_d;

   always_comb begin
      dirty_d = dirty_q;
      cnt_d   = cnt_q;
      fire_d  = 1'b0;
      if (clear) begin
         dirty_d = 1'b0;
         cnt_d   = '0;
      end else if (we && enable) begin
         dirty_d = 1'b1;
         cnt_d   = '0;
      end else if (dirty_q) begin
         if (cnt_q == CW'(CYC - 1)) begin
            fire_d  = 1'b1;
            dirty_d = 1'b0;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dirty_q <= 1'b0;
         cnt_q   <= '0;
         fire_q  <= 1'b0;
      end else begin
         dirty_q <= dirty_d;
         cnt_q   <= cnt_d;
         fire_q  <= fire_d;
      end
   end

   assign fire = fire_q;

endmodule

// File: rtl/bk_sector_seq.sv
// rtl/bk_sector_seq.sv - nvram <-> SAV image sector sequencer over the user_io SD handshake
// Optional autosave on nvram write inactivity is built when BK_AUTOSAVE_EN is defined.
module bk_sector_seq
   import bk_pkg::*;
#(
   parameter int          SECTORS      = 16,
   parameter int unsigned AUTOSAVE_CYC = 32'd16777215
) (
   input  logic            clk_sys,
   input  logic            RESET_n,
   input  logic            img_mounted,
   input  logic [31:0]     img_size,
   input  logic            save_req,
   input  logic            download,
   input  logic            nvram_we,
   bk_sector_seq_if.master sd,
   output logic            bk_ena,
   output logic            bk_busy,
   output logic            bk_reset
);

   localparam logic [7:0] LBA_LAST = lba_last(SECTORS);

   logic      mnt_prev_q, mnt_prev_d;
   logic      save_prev_q, save_prev_d;
   logic      dl_prev_q, dl_prev_d;
   logic      ack_prev_q, ack_prev_d;
   logic      ena_q, ena_d;
   logic      load_pend_q, load_pend_d;
   logic      save_pend_q, save_pend_d;
   bk_state_e state_q, state_d;
   logic      dir_q, dir_d;
   logic [7:0] lba_q, lba_d;
   logic      rd_q, rd_d;
   logic      wr_q, wr_d;
   logic      busy_q, busy_d;
   logic      reset_q, reset_d;

   logic mnt_rise, save_rise, dl_rise, ack_rise, ack_fall;
   logic loading, as_fire;

   assign mnt_rise  = img_mounted & ~mnt_prev_q;
   assign save_rise = save_req & ~save_prev_q;
   assign dl_rise   = download & ~dl_prev_q;
   assign ack_rise  = sd.sd_ack & ~ack_prev_q;
   assign ack_fall  = ~sd.sd_ack & ack_prev_q;
   assign loading   = dir_q && (state_q != ST_IDLE);

`ifdef BK_AUTOSAVE_EN
   bk_autosave_timer #(.CYC(AUTOSAVE_CYC)) u_autosave (
      .clk    (clk_sys),
      .rst_n  (RESET_n),
      .we     (nvram_we),
      .enable (ena_q && !loading),
      .clear  (dl_rise),
      .fire   (as_fire)
   );
`else
   logic unused_autosave;
   assign as_fire         = 1'b0;
   assign unused_autosave = nvram_we ^ loading ^ (AUTOSAVE_CYC == 0);
`endif

   always_comb begin
      mnt_prev_d  = img_mounted;
      save_prev_d = save_req;
      dl_prev_d   = download;
      ack_prev_d  = sd.sd_ack;
      ena_d       = ena_q;
      load_pend_d = load_pend_q;
      save_pend_d = save_pend_q;
      state_d     = state_q;
      dir_d       = dir_q;
      lba_d       = lba_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      reset_d     = 1'b0;

      // Pending work is consumed when a transfer starts, so requests arriving
      // mid-transfer survive DONE and are served on the next pass.
      case (state_q)
         ST_IDLE: begin
            if (ena_q && (load_pend_q || save_pend_q)) begin
               lba_d       = 8'd0;
               dir_d       = load_pend_q;
               rd_d        = load_pend_q;
               wr_d        = ~load_pend_q;
               save_pend_d = 1'b0;
               load_pend_d = 1'b0;
               state_d     = ST_REQ;
            end
         end
         ST_REQ: begin
            if (ack_rise) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (ack_fall) begin
               if (lba_q == LBA_LAST) begin
                  reset_d = dir_q;
                  state_d = ST_DONE;
               end else begin
                  lba_d   = lba_q + 8'd1;
                  rd_d    = dir_q;
                  wr_d    = ~dir_q;
                  state_d = ST_REQ;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (mnt_rise && (img_size != 32'd0)) begin
         ena_d       = 1'b1;
         load_pend_d = 1'b1;
      end
      if ((save_rise || as_fire) && ena_q)
         save_pend_d = 1'b1;
      // Download wins over everything arriving in the same cycle.
      if (dl_rise) begin
         ena_d       = 1'b0;
         load_pend_d = 1'b0;
         save_pend_d = 1'b0;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         mnt_prev_q  <= 1'b0;
         save_prev_q <= 1'b0;
         dl_prev_q   <= 1'b0;
         ack_prev_q  <= 1'b0;
         ena_q       <= 1'b0;
         load_pend_q <= 1'b0;
         save_pend_q <= 1'b0;
         state_q     <= ST_IDLE;
         dir_q       <= 1'b0;
         lba_q       <= 8'd0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
         busy_q      <= 1'b0;
         reset_q     <= 1'b0;
      end else begin
         mnt_prev_q  <= mnt_prev_d;
         save_prev_q <= save_prev_d;
         dl_prev_q   <= dl_prev_d;
         ack_prev_q  <= ack_prev_d;
         ena_q       <= ena_d;
         load_pend_q <= load_pend_d;
         save_pend_q <= save_pend_d;
         state_q     <= state_d;
         dir_q       <= dir_d;
         lba_q       <= lba_d;
         rd_q        <= rd_d;
         wr_q        <= wr_d;
         busy_q      <= busy_d;
         reset_q     <= reset_d;
      end
   end

   assign sd.sd_lba = {24'd0, lba_q};
   assign sd.sd_rd  = rd_q;
   assign sd.sd_wr  = wr_q;
   assign bk_ena    = ena_q;
   assign bk_busy   = busy_q;
   assign bk_reset  = reset_q;

endmodule

// File: tb/tb_bk_sector_seq.sv
// tb/tb_bk_sector_seq.sv - self-checking bench for bk_sector_seq (autosave cases built with BK_AUTOSAVE_EN)
module tb_bk_sector_seq;

   typedef struct packed {
      logic       dir;
      logic [7:0] lba;
   } exp_t;

   logic        clk;
   logic        RESET_n;
   logic        img_mounted;
   logic [31:0] img_size;
   logic        save_req;
   logic        download;
   logic        nvram_we;
   logic        bk_ena;
   logic        bk_busy;
   logic        bk_reset;

   bk_sector_seq_if sd_if ();

   bk_sector_seq #(.SECTORS(16), .AUTOSAVE_CYC(100)) dut (
      .clk_sys     (clk),
      .RESET_n     (RESET_n),
      .img_mounted (img_mounted),
      .img_size    (img_size),
      .save_req    (save_req),
      .download    (download),
      .nvram_we    (nvram_we),
      .sd          (sd_if),
      .bk_ena      (bk_ena),
      .bk_busy     (bk_busy),
      .bk_reset    (bk_reset)
   );

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   logic m_ena = 1'b0;
   int   pulses = 0;
   logic rst_prev_tb = 1'b0;
   logic run_cmp = 1'b0;
   logic host_hold = 1'b0;
   int   host_cnt = 0;
   int   host_lba = -1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic push_xfer(input logic dir, input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.dir = dir;
         e.lba = 8'(i);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || bk_busy !== 1'b0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(n < budget), 64'd1);
   endtask

   task automatic wait_cnt(input string name, input int target, input int budget);
      int n = 0;
      while (host_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'(n < budget), 64'd1);
   endtask

   task automatic pulse_mount(input logic [31:0] size);
      @(posedge clk); #1;
      img_size    = size;
      img_mounted = 1'b1;
      @(posedge clk); #1;
      if (size != 32'd0) m_ena = 1'b1;
      @(posedge clk); #1;
      img_mounted = 1'b0;
   endtask

   task automatic pulse_save();
      @(posedge clk); #1 save_req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1 save_req = 1'b0;
   endtask

   // Per-cycle comparison of outputs against the abstract model.
   always @(negedge clk) begin
      if (run_cmp) begin
         check("ena", 64'(bk_ena), 64'(m_ena));
         check("lba_upper", 64'(sd_if.sd_lba[31:8]), 64'd0);
         check("rd_wr_excl", 64'(sd_if.sd_rd & sd_if.sd_wr), 64'd0);
         if (sd_if.sd_rd || sd_if.sd_wr) check("busy_in_req", 64'(bk_busy), 64'd1);
         check("reset_width", 64'(bk_reset & rst_prev_tb), 64'd0);
         if (bk_reset && !rst_prev_tb) pulses++;
         rst_prev_tb = bk_reset;
      end
   end

   // SD host: acknowledges each request and checks it against the expected sector list.
   initial begin
      exp_t        e;
      logic        d;
      logic [31:0] l;
      sd_if.sd_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (!host_hold && RESET_n && (sd_if.sd_rd || sd_if.sd_wr)) begin
            d = sd_if.sd_rd;
            l = sd_if.sd_lba;
            if (exp_q.size() == 0) begin
               check("unexpected_req", {31'd0, d, l}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("req_dir", 64'(d), 64'(e.dir));
               check("req_lba", 64'(l), 64'(e.lba));
            end
            host_lba = int'(l);
            host_cnt++;
            @(posedge clk); #1 sd_if.sd_ack = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check("req_drop", 64'(sd_if.sd_rd | sd_if.sd_wr), 64'd0);
            @(posedge clk); #1 sd_if.sd_ack = 1'b0;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int c0;
      int n;
      RESET_n     = 1'b0;
      img_mounted = 1'b0;
      img_size    = 32'd0;
      save_req    = 1'b0;
      download    = 1'b0;
      nvram_we    = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ena", 64'(bk_ena), 64'd0);
      check("rst_busy", 64'(bk_busy), 64'd0);
      check("rst_reset", 64'(bk_reset), 64'd0);
      check("rst_rd", 64'(sd_if.sd_rd), 64'd0);
      check("rst_wr", 64'(sd_if.sd_wr), 64'd0);
      check("rst_lba", 64'(sd_if.sd_lba), 64'd0);
      @(posedge clk); #1 RESET_n = 1'b1;
      run_cmp = 1'b1;

      // Zero-size mount is ignored; a save request then does nothing.
      pulse_mount(32'd0);
      check("zero_mount_ena", 64'(bk_ena), 64'd0);
      pulse_save();
      repeat (20) @(negedge clk);
      check("zero_mount_no_xfer", 64'(host_cnt), 64'd0);

      // Load on mount: 16 reads, then one bk_reset pulse.
      push_xfer(1'b1, 16);
      pulse_mount(32'd8192);
      wait_done("load_done", 400);
      check("load_count", 64'(host_cnt), 64'd16);
      check("load_pulses", 64'(pulses), 64'd1);

      // Save: request edge reaches sd_wr two cycles later; no reset pulse.
      push_xfer(1'b0, 16);
      c0 = host_cnt;
      @(posedge clk); #1 save_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("save_lat_1", 64'(sd_if.sd_wr), 64'd0);
      @(posedge clk);
      @(negedge clk);
      check("save_lat_2", 64'(sd_if.sd_wr), 64'd1);
      @(posedge clk); #1 save_req = 1'b0;
      wait_done("save_done", 400);
      check("save_count", 64'(host_cnt), 64'(c0 + 16));
      check("save_pulses", 64'(pulses), 64'd1);

      // Second save request at sector 5 runs a second full save.
      push_xfer(1'b0, 16);
      push_xfer(1'b0, 16);
      c0 = host_cnt;
      pulse_save();
      wait_cnt("resave_reach5", c0 + 6, 400);
      check("resave_at5", 64'(host_lba), 64'd5);
      pulse_save();
      wait_done("resave_done", 800);
      check("resave_count", 64'(host_cnt), 64'(c0 + 32));

`ifdef BK_AUTOSAVE_EN
      // One write, then quiet: automatic save from sector 0.
      push_xfer(1'b0, 16);
      c0 = host_cnt;
      @(posedge clk); #1 nvram_we = 1'b1;
      @(posedge clk); #1 nvram_we = 1'b0;
      n = 0;
      while (!sd_if.sd_wr && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("autosave_lat", 64'(n >= 100 && n <= 106), 64'd1);
      check("autosave_lba", 64'(sd_if.sd_lba), 64'd0);
      wait_done("autosave_done", 400);
      check("autosave_count", 64'(host_cnt), 64'(c0 + 16));

      // A second write 50 cycles in restarts the idle count.
      push_xfer(1'b0, 16);
      @(posedge clk); #1 nvram_we = 1'b1;
      @(posedge clk); #1 nvram_we = 1'b0;
      n = 0;
      for (int i = 0; i < 49; i++) begin
         @(negedge clk);
         if (sd_if.sd_wr) n++;
      end
      check("autosave_no_early", 64'(n), 64'd0);
      @(posedge clk); #1 nvram_we = 1'b1;
      @(posedge clk); #1 nvram_we = 1'b0;
      n = 0;
      while (!sd_if.sd_wr && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("autosave_delay", 64'(n >= 100 && n <= 106), 64'd1);
      wait_done("autosave2_done", 400);
`endif

      // Download at sector 7 of a save: sectors 7..15 complete, then disabled.
      push_xfer(1'b0, 16);
      c0 = host_cnt;
      pulse_save();
      wait_cnt("dl_reach7", c0 + 8, 400);
      check("dl_at7", 64'(host_lba), 64'd7);
      @(posedge clk); #1 download = 1'b1;
      @(posedge clk); #1 m_ena = 1'b0;
      wait_done("dl_done", 400);
      check("dl_count", 64'(host_cnt), 64'(c0 + 16));
      check("dl_ena", 64'(bk_ena), 64'd0);
      pulse_save();
      repeat (30) @(negedge clk);
      check("dl_save_ignored", 64'(host_cnt), 64'(c0 + 16));

      // Remount, then reset while a write request is held.
      @(posedge clk); #1 download = 1'b0;
      push_xfer(1'b1, 16);
      pulse_mount(32'd8192);
      wait_done("reload_done", 400);
      check("reload_pulses", 64'(pulses), 64'd2);
      host_hold = 1'b1;
      @(posedge clk); #1 save_req = 1'b1;
      n = 0;
      while (!sd_if.sd_wr && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("hold_wr_seen", 64'(n < 50), 64'd1);
      @(posedge clk); #1;
      RESET_n = 1'b0;
      m_ena   = 1'b0;
      #1;
      check("rst_mid_wr", 64'(sd_if.sd_wr), 64'd0);
      check("rst_mid_rd", 64'(sd_if.sd_rd), 64'd0);
      check("rst_mid_busy", 64'(bk_busy), 64'd0);
      check("rst_mid_lba", 64'(sd_if.sd_lba), 64'd0);
      save_req = 1'b0;
      repeat (3) @(posedge clk);
      #1 RESET_n = 1'b1;
      host_hold = 1'b0;
      c0 = host_cnt;
      repeat (40) @(negedge clk);
      check("rst_no_pending", 64'(host_cnt), 64'(c0));
      check("rst_busy_after", 64'(bk_busy), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
